// File: rtl/seg_scan_ctrl.sv
// Scans a double-buffered digit store onto a seven-segment decoder with guarded, active-low digit enables.
// num is registered on GUARD entry; dig_n is gated by en so the display goes dark in the same cycle en falls.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int ADDR_W    = 2,
  parameter int ON_CYCLES = 1000,
  parameter int GUARD     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              blank_lz,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              commit,
  output logic              pending,
  output logic [3:0]        num,
  output logic [DIGITS-1:0] dig_n,
  output logic              frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int MAXC  = (ON_CYCLES > GUARD) ? ON_CYCLES : GUARD;
  localparam int CNT_W = $clog2(MAXC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GUARD = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        shadow [DIGITS];
  logic [3:0]        active [DIGITS];

  logic              guard_last;
  logic              on_last;
  logic              boundary;
  logic              do_copy;
  logic [IDX_W-1:0]  idx_nxt;
  logic [IDX_W-1:0]  load_slot;
  logic [3:0]        load_val;
  logic [DIGITS-1:0] sup;
  logic              lz_run;

  assign guard_last = (cnt == CNT_W'(GUARD - 1));
  assign on_last    = (cnt == CNT_W'(ON_CYCLES - 1));
  assign boundary   = en && (state == S_ON) && on_last && (idx == IDX_W'(DIGITS - 1));
  assign do_copy    = ((state == S_IDLE) && pending) || (boundary && (pending || commit));
  assign idx_nxt    = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
  assign load_slot  = (state == S_ON) ? idx_nxt : '0;
  // A copy on this edge means the next slot must show the freshly copied shadow value.
  assign load_val   = do_copy ? shadow[load_slot] : active[load_slot];

  always_comb begin
    sup    = '0;
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_run = lz_run && (active[i] == 4'd0);
      sup[i] = blank_lz && lz_run;
    end
  end

  always_comb begin
    dig_n = '1;
    if (en && (state == S_ON) && !sup[idx]) begin
      dig_n[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      num        <= 4'd0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= 4'd0;
        active[i] <= 4'd0;
      end
    end else begin
      frame_done <= boundary;

      if (wr_en && (int'(wr_addr) < DIGITS)) begin
        shadow[IDX_W'(wr_addr)] <= wr_data;
      end

      if (do_copy) begin
        for (int i = 0; i < DIGITS; i++) begin
          active[i] <= shadow[i];
        end
        pending <= 1'b0;
      end else if (commit) begin
        pending <= 1'b1;
      end

      if (!en) begin
        state <= S_IDLE;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_GUARD;
            idx   <= '0;
            cnt   <= '0;
            num   <= load_val;
          end
          S_GUARD: begin
            if (guard_last) begin
              state <= S_ON;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_ON: begin
            if (on_last) begin
              state <= S_GUARD;
              cnt   <= '0;
              idx   <= idx_nxt;
              num   <= load_val;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
